sreg_serial_feeder: RTL

//  Upstream stage for the bidirectional shift register. Accepts a parallel word over a

---
 rtl/sreg_pkg.sv | 13 +
 rtl/sreg_bit_timer.sv | 46 ++++
 rtl/sreg_serial_feeder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sreg_pkg.sv
// Shared types and constants for the shift-register serial feeder.
package sreg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } feeder_state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/sreg_bit_timer.sv
// Bit-period prescaler for the serial feeder.
// The timer looks one cycle ahead. 'run' says whether the coming cycle belongs
// to a transfer. 'hold' says the current cycle is stalled. 'tick' is a register
// that is high during the last cycle of each DIV-cycle bit period.
module sreg_bit_timer #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    input  logic hold,
    output logic tick
);

    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic ONE_CYCLE = (DIV == 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          active;

    assign cnt_inc = cnt + CW'(1);

    // Period counter: restart on entry, freeze on hold, reload to 0 after the last cycle
    always_ff @(posedge clk) begin
        if (clr || !run) begin
            cnt    <= '0;
            tick   <= 1'b0;
            active <= 1'b0;
        end else if (!active) begin
            cnt    <= '0;
            tick   <= ONE_CYCLE;
            active <= 1'b1;
        end else if (!hold) begin
            if (tick) begin
                cnt  <= '0;
                tick <= ONE_CYCLE;
            end else begin
                cnt  <= cnt_inc;
                tick <= (cnt_inc == LAST);
            end
        end
    end

endmodule

// File: rtl/sreg_serial_feeder.sv
// Serializer that feeds the bidirectional shift register one bit per period.
// The word is reordered at acceptance so the same LSB-first buffer serves both
// directions, and the register ends up holding the original word.
// Optional macro SREG_FEEDER_STALL_EN adds a 'stall' input that stretches the
// current bit period for as long as it is held high during a transfer.
module sreg_serial_feeder
    import sreg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             clr,
`ifdef SREG_FEEDER_STALL_EN
    input  logic             stall,
`endif
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_dir,
    output logic             ser_in,
    output logic             ser_en,
    output logic             ser_dir,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    feeder_state_t    state;
    feeder_state_t    state_next;
    logic [WIDTH-1:0] shift_buf;
    logic [WIDTH-1:0] shift_buf_next;
    logic [WIDTH-1:0] data_ordered;
    logic [BW-1:0]    bit_idx;
    logic [BW-1:0]    bit_idx_next;
    logic             ser_in_next;
    logic             stall_eff;
    logic             tick;
    logic             period_end;
    logic             accept;
    logic             timer_run;
    logic             timer_hold;

`ifdef SREG_FEEDER_STALL_EN
    assign stall_eff = stall;
    assign ser_en    = tick && !stall;
`else
    assign stall_eff = 1'b0;
    assign ser_en    = tick;
`endif

    assign load_ready = (state == ST_IDLE) && !clr;
    assign accept     = load_valid && load_ready;
    assign period_end = (state == ST_SHIFT) && tick && !stall_eff;
    assign timer_run  = (state_next == ST_SHIFT);
    assign timer_hold = (state == ST_SHIFT) && stall_eff;

    sreg_bit_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk  (clk),
        .clr  (clr),
        .run  (timer_run),
        .hold (timer_hold),
        .tick (tick)
    );

    // State register; clear aborts any transfer at once
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: the last bit period ends the transfer, DONE lasts a single cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_SHIFT;
            ST_SHIFT: if (period_end && (bit_idx == LAST_BIT)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Reorder the incoming word so the first bit to send always sits at index 0
    always_comb begin
        data_ordered = load_data;
        for (int i = 0; i < WIDTH; i++) begin
            data_ordered[i] = (load_dir == DIR_LEFT) ? load_data[WIDTH-1-i] : load_data[i];
        end
    end

    // Output/datapath decode: load on acceptance, advance one bit per completed period
    always_comb begin
        shift_buf_next = shift_buf;
        bit_idx_next   = bit_idx;
        if (accept) begin
            shift_buf_next = data_ordered;
            bit_idx_next   = '0;
        end else if (period_end) begin
            shift_buf_next = shift_buf >> 1;
            bit_idx_next   = bit_idx + BW'(1);
        end
        ser_in_next = (state_next == ST_SHIFT) ? shift_buf_next[0] : 1'b0;
    end

    // Registered datapath and outputs, all derived from the upcoming state
    always_ff @(posedge clk) begin
        if (clr) begin
            shift_buf <= '0;
            bit_idx   <= '0;
            ser_in    <= 1'b0;
            ser_dir   <= DIR_RIGHT;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            shift_buf <= shift_buf_next;
            bit_idx   <= bit_idx_next;
            ser_in    <= ser_in_next;
            if (accept) begin
                ser_dir <= load_dir;
            end
            busy <= (state_next != ST_IDLE);
            done <= (state_next == ST_DONE);
        end
    end

endmodule
